bfm_ahbarbiter: RTL and testbench
=================================

Name: bfm_ahbarbiter

Overview:
- Round-robin AHB bus arbiter for the BFM test fabric.
- Shares one AHB slave port, such as the BFM AHB slave model, between up to four BFM masters.
- Drives one-hot grants, the registered current-owner index HMASTER and HMASTLOCK, which steer the address/control and write-data multiplexers.
- Honours fixed-length bursts and locked sequences so that a burst or locked transfer is never split.

Parameters:
- NMASTERS, 4, number of requesters, legal 1..4; unused request bits are ignored.
- DEFAULT_MASTER, 0, index granted when no master requests; must be < NMASTERS.

Ports:
- HCLK  input  1  system clock; all state on rising edge.
- HRESET  input  1  synchronous reset, active-high.
- HBUSREQ  input  NMASTERS  per-master bus request.
- HLOCK  input  NMASTERS  per-master lock request.
- HTRANS  input  2  transfer type of the current address phase, after the mux.
- HBURST  input  3  burst type of the current address phase.
- HREADY  input  1  bus ready, from the slave HREADYOUT.
- HGRANT  output  NMASTERS  one-hot grant, registered.
- HMASTER  output  2  index of the master owning the current address phase, registered.
- HMASTLOCK  output  1  current address phase is locked, registered.

Behaviour:
- Reset (HRESET=1 at an HCLK edge), whether idle or mid-burst:
  - HGRANT = one-hot(DEFAULT_MASTER); HMASTER = DEFAULT_MASTER; HMASTLOCK = 0.
  - beats_left = 0; last_owner = DEFAULT_MASTER.
- Beat counter beats_left (4 bits), updated only on HREADY=1 edges:
  - HTRANS=NONSEQ loads the burst length minus 1: SINGLE and INCR load 0; INCR4/WRAP4 load 3; INCR8/WRAP8 load 7; INCR16/WRAP16 load 15.
  - HTRANS=SEQ decrements by 1, saturating at 0.
  - IDLE and BUSY leave the counter unchanged.
- Arbitration-allowed condition ARB_OK, combinational. ARB_OK requires HREADY=1 and one of:
  - HTRANS=IDLE;
  - HTRANS=NONSEQ with a SINGLE or INCR burst;
  - HTRANS=SEQ with an INCR burst;
  - HTRANS=NONSEQ with a fixed-length burst whose loaded value would be 0 (none for legal codes);
  - HTRANS=SEQ with beats_left==1, i.e. the last beat of a fixed burst.
  - HTRANS=BUSY never permits arbitration.
- Lock hold: if HLOCK[g] and HBUSREQ[g] are both set for the granted master g, ARB_OK is forced to 0 and the grant stays with g.
- Winner selection, when ARB_OK=1:
  - Search HBUSREQ round-robin starting at last_owner+1 modulo NMASTERS, wrapping, including last_owner itself as the final candidate.
  - The first requester found wins.
  - With no requester, the winner is DEFAULT_MASTER.
  - HGRANT takes one-hot(winner) at the next edge.
  - When ARB_OK=0, HGRANT holds.
- Owner update, on each HREADY=1 edge:
  - HMASTER takes the index of the HGRANT value present before the edge.
  - HMASTLOCK takes HLOCK[that index].
  - last_owner takes the same index.
  - When HREADY=0, HMASTER, HMASTLOCK and last_owner hold; wait states never move ownership.
- Latency:
  - A request rising while the bus is IDLE with HREADY=1 yields HGRANT one edge later.
  - HMASTER follows on the next HREADY=1 edge.
  - The new master drives its NONSEQ in that next address phase.
- Simultaneous requests: round-robin pointer order decides; no master wins twice in a row while another is requesting at arbitration points.
- Lock release: when HLOCK drops, normal arbitration resumes at the next ARB_OK point. HMASTLOCK clears on the next HREADY=1 edge.
- Out-of-range masters (index >= NMASTERS): never granted; their inputs are ignored.
- HGRANT is always exactly one-hot.

Test Plan:
- Reset check: HRESET=1 for 2 cycles, then release with no requests → HGRANT=0001, HMASTER=0, HMASTLOCK=0.
- Single request: HBUSREQ=0100 while the bus is IDLE with HREADY=1 → HGRANT=0100 after 1 edge; HMASTER=2 after the 2nd edge.
- Fixed burst: master 1 runs INCR4 while master 3 requests from beat 1 → HGRANT stays 0010 through beats 1-3; HGRANT=1000 on the edge after beat 4 (SEQ, beats_left==1, HREADY=1); a 2-cycle wait state on beat 3 delays the switch by 2 cycles.
- Round-robin: all four request continuously, each issuing SINGLE NONSEQ transfers → grant order 1,2,3,0,1..., starting from owner 0.
- Lock: master 0 asserts HLOCK with 3 SINGLE transfers while master 2 requests → HGRANT stays 0001 and HMASTLOCK=1 throughout; after HLOCK drops, HGRANT=0100 at the next IDLE/NONSEQ point and HMASTLOCK returns to 0.
- Reset mid-burst: HRESET asserted during WRAP8 beat 4 of master 3 → the next edge gives HGRANT=0001, HMASTER=0, beats_left=0.

Source files
------------

// File: rtl/bfm_ahbarbiter.sv
// Round-robin AHB arbiter sharing one slave port between up to four BFM masters.
// Grants move only at points where a fixed-length burst or a locked sequence
// cannot be split; HMASTER/HMASTLOCK follow the grant on HREADY edges.
module bfm_ahbarbiter #(
  parameter int NMASTERS       = 4,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                HCLK,
  input  logic                HRESET,
  input  logic [NMASTERS-1:0] HBUSREQ,
  input  logic [NMASTERS-1:0] HLOCK,
  input  logic [1:0]          HTRANS,
  input  logic [2:0]          HBURST,
  input  logic                HREADY,
  output logic [NMASTERS-1:0] HGRANT,
  output logic [1:0]          HMASTER,
  output logic                HMASTLOCK
);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } trans_e;

  typedef enum logic [2:0] {
    BU_SINGLE = 3'd0,
    BU_INCR   = 3'd1,
    BU_WRAP4  = 3'd2,
    BU_INCR4  = 3'd3,
    BU_WRAP8  = 3'd4,
    BU_INCR8  = 3'd5,
    BU_WRAP16 = 3'd6,
    BU_INCR16 = 3'd7
  } burst_e;

  localparam logic [1:0]          DEF_IDX   = 2'(DEFAULT_MASTER);
  localparam logic [NMASTERS-1:0] DEF_GRANT = NMASTERS'(1) << DEFAULT_MASTER;

  // Request/lock vectors widened to four so indexing by a 2-bit owner is always in range;
  // bits above NMASTERS are zero, which keeps out-of-range masters out of arbitration.
  logic [3:0] req_all;
  logic [3:0] lock_all;
  assign req_all  = 4'(HBUSREQ);
  assign lock_all = 4'(HLOCK);

  logic [3:0]          beats_left;
  logic [1:0]          last_owner;
  logic [1:0]          grant_idx;
  logic [3:0]          burst_len_m1;
  logic                phase_ok;
  logic                lock_hold;
  logic                arb_ok;
  logic [1:0]          winner;
  logic [1:0]          cand;
  logic                found;
  logic [NMASTERS-1:0] grant_next;

  // Encode the one-hot grant into the index of the granted master.
  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NMASTERS; i++)
      if (HGRANT[i]) grant_idx = i[1:0];
  end

  // Beat count minus one for the burst type on the bus.
  always_comb begin
    burst_len_m1 = 4'd0;
    case (HBURST)
      BU_WRAP4,  BU_INCR4:  burst_len_m1 = 4'd3;
      BU_WRAP8,  BU_INCR8:  burst_len_m1 = 4'd7;
      BU_WRAP16, BU_INCR16: burst_len_m1 = 4'd15;
      default:              burst_len_m1 = 4'd0;
    endcase
  end

  // Decide whether the current address phase is a legal point to hand over the bus.
  always_comb begin
    phase_ok = 1'b0;
    case (HTRANS)
      TR_IDLE:   phase_ok = 1'b1;
      TR_NONSEQ: phase_ok = (HBURST == BU_SINGLE) || (HBURST == BU_INCR) ||
                            (burst_len_m1 == 4'd0);
      TR_SEQ:    phase_ok = (HBURST == BU_INCR) || (beats_left == 4'd1);
      default:   phase_ok = 1'b0;
    endcase
  end

  assign lock_hold = lock_all[grant_idx] & req_all[grant_idx];
  assign arb_ok    = HREADY & phase_ok & ~lock_hold;

  // Round-robin search starting after the last owner; the last owner itself is tried last.
  always_comb begin
    winner = DEF_IDX;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NMASTERS; k++) begin
      cand = 2'((int'(last_owner) + k) % NMASTERS);
      if (!found && req_all[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  // One-hot form of the selected winner.
  always_comb begin
    grant_next = '0;
    for (int i = 0; i < NMASTERS; i++)
      grant_next[i] = (winner == i[1:0]);
  end

  // Grant, owner and beat-counter registers; wait states freeze ownership and the counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      HGRANT     <= DEF_GRANT;
      HMASTER    <= DEF_IDX;
      HMASTLOCK  <= 1'b0;
      last_owner <= DEF_IDX;
      beats_left <= 4'd0;
    end else begin
      if (arb_ok) HGRANT <= grant_next;
      if (HREADY) begin
        HMASTER    <= grant_idx;
        HMASTLOCK  <= lock_all[grant_idx];
        last_owner <= grant_idx;
        case (HTRANS)
          TR_NONSEQ: beats_left <= burst_len_m1;
          TR_SEQ:    if (beats_left != 4'd0) beats_left <= beats_left - 4'd1;
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bfm_ahbarbiter.sv
// Self-checking bench for bfm_ahbarbiter: a behavioural model feeds a scoreboard
// that is checked after every edge, plus directed scenario checks.
module tb_bfm_ahbarbiter;

  logic       HCLK = 1'b0;
  logic       HRESET;
  logic [3:0] HBUSREQ;
  logic [3:0] HLOCK;
  logic [1:0] HTRANS;
  logic [2:0] HBURST;
  logic       HREADY;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER;
  logic       HMASTLOCK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] g;
    logic [1:0] m;
    logic       l;
  } exp_t;

  exp_t sb[$];

  // model state
  int m_gidx   = 0;
  int m_master = 0;
  int m_last   = 0;
  int m_beats  = 0;
  bit m_lock   = 1'b0;

  bfm_ahbarbiter #(.NMASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HBUSREQ(HBUSREQ), .HLOCK(HLOCK),
    .HTRANS(HTRANS), .HBURST(HBURST), .HREADY(HREADY),
    .HGRANT(HGRANT), .HMASTER(HMASTER), .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  function automatic int burst_load(input logic [2:0] b);
    if (b < 3'd2)      return 0;
    else if (b < 3'd4) return 3;
    else if (b < 3'd6) return 7;
    else               return 15;
  endfunction

  function automatic int grant_index(input logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    bit ok_t, ok, found;
    int win, c;
    if (HRESET) begin
      m_gidx = 0; m_master = 0; m_last = 0; m_beats = 0; m_lock = 1'b0;
      return;
    end
    case (HTRANS)
      2'b00:   ok_t = 1'b1;
      2'b10:   ok_t = (HBURST == 3'd0) || (HBURST == 3'd1);
      2'b11:   ok_t = (HBURST == 3'd1) || (m_beats == 1);
      default: ok_t = 1'b0;
    endcase
    ok  = HREADY && ok_t && !(HLOCK[m_gidx] && HBUSREQ[m_gidx]);
    win = m_gidx;
    if (ok) begin
      win = 0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
        c = (m_last + k) % 4;
        if (!found && HBUSREQ[c]) begin win = c; found = 1'b1; end
      end
    end
    if (HREADY) begin
      if (HTRANS == 2'b10) m_beats = burst_load(HBURST);
      else if (HTRANS == 2'b11 && m_beats > 0) m_beats = m_beats - 1;
      m_master = m_gidx;
      m_lock   = HLOCK[m_gidx];
      m_last   = m_gidx;
    end
    m_gidx = win;
  endtask

  // Drive one clock with the current inputs; expected outputs go to the scoreboard.
  task automatic cycle();
    exp_t e;
    model_step();
    e.g = 4'(1 << m_gidx);
    e.m = 2'(m_master);
    e.l = m_lock;
    sb.push_back(e);
    @(posedge HCLK);
    #1;
  endtask

  // Scoreboard monitor: compares DUT outputs after each edge with the model.
  initial begin
    exp_t e;
    forever begin
      @(posedge HCLK);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if ({HGRANT, HMASTER, HMASTLOCK} !== {e.g, e.m, e.l}) begin
          errors++;
          $display("FAIL scoreboard t=%0t got grant=%b master=%0d lock=%b want grant=%b master=%0d lock=%b",
                   $time, HGRANT, HMASTER, HMASTLOCK, e.g, e.m, e.l);
        end
        checks++;
        if ($countones(HGRANT) != 1) begin
          errors++;
          $display("FAIL onehot t=%0t got grant=%b want exactly one bit", $time, HGRANT);
        end
      end
    end
  end

  task automatic test_reset();
    HRESET = 1'b1; HBUSREQ = '0; HLOCK = '0; HTRANS = 2'b00; HBURST = 3'd0; HREADY = 1'b1;
    cycle();
    cycle();
    HRESET = 1'b0;
    cycle();
    checks++;
    if (HGRANT !== 4'b0001) begin errors++; $display("FAIL reset_grant got %b want 0001", HGRANT); end
    checks++;
    if (HMASTER !== 2'd0) begin errors++; $display("FAIL reset_master got %0d want 0", HMASTER); end
    checks++;
    if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL reset_mastlock got %b want 0", HMASTLOCK); end
  endtask

  task automatic test_single();
    HBUSREQ = 4'b0100; HTRANS = 2'b00;
    cycle();
    checks++;
    if (HGRANT !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", HGRANT); end
    checks++;
    if (HMASTER !== 2'd0) begin errors++; $display("FAIL single_master_lag got %0d want 0", HMASTER); end
    cycle();
    checks++;
    if (HMASTER !== 2'd2) begin errors++; $display("FAIL single_master got %0d want 2", HMASTER); end
    HBUSREQ = 4'b0000;
    cycle();
  endtask

  task automatic test_fixed_burst();
    logic [1:0] tr[6] = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b11, 2'b11};
    logic       rd[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    HBUSREQ = 4'b0010; HTRANS = 2'b00;
    cycle();
    checks++;
    if (HGRANT !== 4'b0010) begin errors++; $display("FAIL burst_setup_grant got %b want 0010", HGRANT); end
    cycle();
    checks++;
    if (HMASTER !== 2'd1) begin errors++; $display("FAIL burst_setup_master got %0d want 1", HMASTER); end
    HBUSREQ = 4'b1010; HBURST = 3'd3;
    for (int s = 0; s < 6; s++) begin
      HTRANS = tr[s]; HREADY = rd[s];
      cycle();
      checks++;
      if (s < 5 && HGRANT !== 4'b0010) begin
        errors++; $display("FAIL burst_hold step=%0d got %b want 0010", s, HGRANT);
      end else if (s == 5 && HGRANT !== 4'b1000) begin
        errors++; $display("FAIL burst_switch got %b want 1000", HGRANT);
      end
    end
    HBUSREQ = 4'b0000; HTRANS = 2'b00; HBURST = 3'd0; HREADY = 1'b1;
    cycle();
  endtask

  task automatic test_round_robin();
    int order[$];
    int exp_order[5] = '{1, 2, 3, 0, 1};
    int prev, idx;
    HRESET = 1'b1; HBUSREQ = 4'b0000; HTRANS = 2'b00;
    cycle();
    HRESET = 1'b0;
    HBUSREQ = 4'b1111; HTRANS = 2'b10; HBURST = 3'd0;
    prev = grant_index(HGRANT);
    for (int c = 0; c < 10; c++) begin
      cycle();
      idx = grant_index(HGRANT);
      if (idx != prev) order.push_back(idx);
      prev = idx;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= order.size()) begin
        errors++; $display("FAIL rr_order pos=%0d got none want %0d", i, exp_order[i]);
      end else if (order[i] != exp_order[i]) begin
        errors++; $display("FAIL rr_order pos=%0d got %0d want %0d", i, order[i], exp_order[i]);
      end
    end
    HBUSREQ = 4'b0000; HTRANS = 2'b00;
    cycle();
  endtask

  task automatic test_lock();
    HRESET = 1'b1; HBUSREQ = 4'b0000; HLOCK = 4'b0000; HTRANS = 2'b00;
    cycle();
    HRESET = 1'b0;
    HBUSREQ = 4'b0101; HLOCK = 4'b0001;
    cycle();
    checks++;
    if (HGRANT !== 4'b0001 || HMASTLOCK !== 1'b1) begin
      errors++; $display("FAIL lock_start got grant=%b lock=%b want 0001/1", HGRANT, HMASTLOCK);
    end
    HTRANS = 2'b10; HBURST = 3'd0;
    for (int t = 0; t < 3; t++) begin
      cycle();
      checks++;
      if (HGRANT !== 4'b0001 || HMASTLOCK !== 1'b1) begin
        errors++; $display("FAIL lock_hold xfer=%0d got grant=%b lock=%b want 0001/1", t, HGRANT, HMASTLOCK);
      end
    end
    HLOCK = 4'b0000; HBUSREQ = 4'b0100; HTRANS = 2'b00;
    cycle();
    checks++;
    if (HGRANT !== 4'b0100) begin errors++; $display("FAIL lock_release_grant got %b want 0100", HGRANT); end
    checks++;
    if (HMASTLOCK !== 1'b0) begin errors++; $display("FAIL lock_release_mastlock got %b want 0", HMASTLOCK); end
    HBUSREQ = 4'b0000;
    cycle();
  endtask

  task automatic test_reset_mid_burst();
    HBUSREQ = 4'b1000; HTRANS = 2'b00;
    cycle();
    cycle();
    checks++;
    if (HMASTER !== 2'd3) begin errors++; $display("FAIL midrst_setup got %0d want 3", HMASTER); end
    HTRANS = 2'b10; HBURST = 3'd4;
    cycle();
    HTRANS = 2'b11;
    cycle();
    cycle();
    checks++;
    if (dut.beats_left !== 4'd5) begin errors++; $display("FAIL midrst_beats got %0d want 5", dut.beats_left); end
    HRESET = 1'b1;
    cycle();
    checks++;
    if (HGRANT !== 4'b0001 || HMASTER !== 2'd0 || HMASTLOCK !== 1'b0) begin
      errors++; $display("FAIL midrst_state got grant=%b master=%0d lock=%b want 0001/0/0", HGRANT, HMASTER, HMASTLOCK);
    end
    checks++;
    if (dut.beats_left !== 4'd0) begin errors++; $display("FAIL midrst_beats_clr got %0d want 0", dut.beats_left); end
    HRESET = 1'b0; HBUSREQ = 4'b0000; HTRANS = 2'b00; HBURST = 3'd0;
    cycle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 300; c++) begin
      HRESET  = ($urandom_range(0, 59) == 0);
      HBUSREQ = 4'($urandom_range(0, 15));
      HLOCK   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      HTRANS  = 2'($urandom_range(0, 3));
      HBURST  = 3'($urandom_range(0, 7));
      HREADY  = ($urandom_range(0, 3) != 0);
      cycle();
    end
    HRESET = 1'b0; HBUSREQ = 4'b0000; HLOCK = 4'b0000; HTRANS = 2'b00; HREADY = 1'b1;
    cycle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_burst();
    test_round_robin();
    test_lock();
    test_reset_mid_burst();
    test_random();
    #20;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
